rx_usr_if_mc: RTL and testbench
===============================

Name: rx_usr_if_mc

Overview:
Multi-channel, width-parametrised successor to the single-channel rx user interface. It merges NUM_CH independent receive paths onto one user stream, arbitrating at packet granularity. Each path is a first-word-fall-through data FIFO plus a packet-status queue. Good packets stream out with sof/eof/byte-enable and a channel tag. Bad or disabled-channel packets are flushed internally and counted. It sits in the usr_clk domain after the per-port rx engines and async FIFOs.

Parameters:
NUM_CH, 4, number of receive channels (1..8)
DATA_W, 32, data word width in bits (multiple of 8, 8..64)
LEN_W, 14, packet byte-length field width in the status word

Ports:
clk  in  1  user clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
chan_en  in  NUM_CH  per-channel enable; packets from a disabled channel are dropped
ch_dout  in  NUM_CH*(DATA_W+1)  per-channel FWFT data word {last, data}; channel i at slice i
ch_empty  in  NUM_CH  per-channel data FIFO empty
ch_ack  out  NUM_CH  per-channel data FIFO pop
st_dout  in  NUM_CH*(LEN_W+1)  per-channel status {good, byte_len}
st_dv  in  NUM_CH  status word valid
st_ack  out  NUM_CH  status pop; 1-cycle pulse
rx_data  out  DATA_W  user data
rx_be  out  DATA_W/8  byte enables; all ones except on the eof word
rx_sof  out  1  first word of packet
rx_eof  out  1  last word of packet
rx_ch  out  clog2(NUM_CH) (min 1)  source channel of the current packet
rx_dv  out  1  rx_data valid
rx_ack  in  1  user accepts the word when rx_dv and rx_ack are both high
drop_count  out  32  packets dropped (bad or disabled); wraps at 2^32

Behaviour:
- Reset (async assert, sync release): state IDLE; rr pointer 0; drop_count 0; rx_dv, rx_sof, rx_eof, ch_ack and st_ack all 0; rx_ch 0; rx_be all ones.
- State IDLE:
  - Grant goes to the first channel i with st_dv[i], searching round-robin from the rr pointer.
  - In the grant cycle: pulse st_ack[i]; latch cur_ch=i, byte_len and good; set first=1.
  - Next state is XFER if good && chan_en[i], else DROP.
  - No grant when no st_dv is set.
- State XFER:
  - rx_dv = ~ch_empty[cur_ch] (combinational); rx_data and last come from ch_dout slice cur_ch.
  - ch_ack[cur_ch] = rx_dv & rx_ack.
  - rx_sof = rx_dv & first; first clears on the first accepted word.
  - rx_eof = rx_dv & last.
  - On an accepted eof word: go to IDLE; rr pointer = cur_ch+1 mod NUM_CH.
  - With rx_ack low, every output holds stable.
- State DROP:
  - rx_dv = 0; ch_ack[cur_ch] = ~ch_empty[cur_ch].
  - On popping the last word: drop_count += 1; go to IDLE; advance the rr pointer as in XFER.
- rx_be on the eof word: r = byte_len mod (DATA_W/8). If r==0, all ones; else the low r bits set, byte 0 = bits [7:0]. On non-eof words, all ones.
- Packet end is defined by the data-word last flag only; byte_len affects rx_be only.
- Latency:
  - Status valid to grant: 1 cycle.
  - Grant to first rx_dv: 1 cycle, if data is present.
  - Minimum gap: 1 IDLE cycle between packets.
- chan_en is sampled only at grant; changes mid-packet do not abort the transfer.
- Statuses from one channel with the other st_dv bits low: served back-to-back, each separated by IDLE.
- Data FIFO empty mid-packet: stall; no timeout.
- Width rules:
  - drop_count wraps 0xFFFFFFFF to 0.
  - For NUM_CH=1, rx_ch is 1 bit, tied to 0.
- Reset mid-packet: the current packet is abandoned with no further outputs; the upstream FIFOs are reset by the same reset_n.

Decomposition:
- Shared package holds:
  - localparams BE_W=DATA_W/8, CH_W=max(1,clog2(NUM_CH)), DW_W=DATA_W+1, SW_W=LEN_W+1.
  - State encoding IDLE/XFER/DROP.
  - Field offsets: last = bit DATA_W; good = bit LEN_W.
- One natural sub-module, rr_arb: NUM_CH-wide round-robin arbiter with inputs req and ptr, outputs grant_valid and grant_idx; purely combinational.
- The top level holds the FSM, latches, mux and counter.

Test Plan:
- Single good packet on ch0, byte_len=10, DATA_W=32, 3 words, rx_ack=1 → 3 words on rx_dv; sof on word 0, eof on word 2; rx_be 1111,1111,0011; rx_ch=0; drop_count=0.
- ch1 status good=0, 2 words → rx_dv stays 0; ch_ack[1] pops 2 words; drop_count becomes 1; st_ack[1] pulses once.
- st_dv on ch0 and ch2 in the same cycle, rr=0 → ch0 packet fully delivered first, then ch2; a later pending ch0 loses to ch3 if rr=1.
- rx_ack held low 5 cycles mid-packet → rx_data, rx_sof and rx_eof stable; no ch_ack; resumes with no word lost or duplicated.
- chan_en[3]=0 with a good packet on ch3 → dropped, drop_count increments; a packet in flight when chan_en changes completes normally.
- reset_n asserted mid-XFER → all outputs 0 immediately, asynchronously; after release the first good packet is delivered with sof and drop_count=0.

Source files
------------

// File: rtl/rx_usr_if_mc_pkg.sv
// -----------------------------------------------------------------------------
// rx_usr_if_mc_pkg
// Shared types and helpers for the multi-channel rx user interface.
//   state_e  : top-level FSM encoding (IDLE / XFER / DROP)
//   ch_bits  : width of a channel index, never less than 1
//   Defaults : NUM_CH_DEF / DATA_W_DEF / LEN_W_DEF parameter defaults
// Field layout used by the top level:
//   data word   {last, data}   -> last at bit DATA_W
//   status word {good, len}    -> good at bit LEN_W
// -----------------------------------------------------------------------------
package rx_usr_if_mc_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // A single channel still needs a 1-bit tag so rx_ch has a legal width.
    function automatic int ch_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rx_usr_if_mc_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin arbiter. Searches req starting at ptr and wrapping
// modulo NUM_CH; the first set bit wins.
//   req         in  NUM_CH  request vector
//   ptr         in  CH_W    search start (highest priority channel)
//   grant_valid out 1       any request present
//   grant_idx   out CH_W    winning channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arb
    import rx_usr_if_mc_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = ch_bits(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_idx
);

    // Scan from the farthest offset down to offset 0 so the nearest request
    // to ptr is the last one written and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_CH]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'((int'(ptr) + k) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/rx_usr_if_mc.sv
// -----------------------------------------------------------------------------
// rx_usr_if_mc
// Merges NUM_CH receive paths (FWFT data FIFO + status queue each) onto one
// user stream, arbitrating per packet. Good packets from enabled channels are
// streamed with sof/eof/be/channel tag; bad or disabled packets are drained
// and counted.
//   clk, reset_n       clock, async active-low reset
//   chan_en            per-channel enable, sampled at grant
//   ch_dout/ch_empty   per-channel {last,data} FWFT word and empty flag
//   ch_ack             per-channel data pop
//   st_dout/st_dv      per-channel {good,byte_len} status and valid
//   st_ack             per-channel status pop (1-cycle pulse at grant)
//   rx_data/rx_be      user data and byte enables
//   rx_sof/rx_eof      packet delimiters
//   rx_ch              source channel of current packet
//   rx_dv/rx_ack       valid/accept handshake
//   drop_count         wrapping count of dropped packets
// -----------------------------------------------------------------------------
module rx_usr_if_mc
    import rx_usr_if_mc_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int LEN_W  = LEN_W_DEF,
    localparam int BE_W   = DATA_W / 8,
    localparam int CH_W   = ch_bits(NUM_CH),
    localparam int DW_W   = DATA_W + 1,
    localparam int SW_W   = LEN_W + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        chan_en,
    input  logic [NUM_CH*DW_W-1:0]   ch_dout,
    input  logic [NUM_CH-1:0]        ch_empty,
    output logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH*SW_W-1:0]   st_dout,
    input  logic [NUM_CH-1:0]        st_dv,
    output logic [NUM_CH-1:0]        st_ack,
    output logic [DATA_W-1:0]        rx_data,
    output logic [BE_W-1:0]          rx_be,
    output logic                     rx_sof,
    output logic                     rx_eof,
    output logic [CH_W-1:0]          rx_ch,
    output logic                     rx_dv,
    input  logic                     rx_ack,
    output logic [31:0]              drop_count
);

    logic [NUM_CH-1:0][DW_W-1:0] dout_a;
    logic [NUM_CH-1:0][SW_W-1:0] st_a;
    assign dout_a = ch_dout;
    assign st_a   = st_dout;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              first_q, first_d;
    logic [31:0]       drop_q, drop_d;

    logic              gnt_v;
    logic [CH_W-1:0]   gnt_idx;

    rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req         (st_dv),
        .ptr         (rr_q),
        .grant_valid (gnt_v),
        .grant_idx   (gnt_idx)
    );

    logic [DW_W-1:0]   cur_word;
    logic              cur_empty;
    logic              cur_last;
    logic [CH_W-1:0]   rr_next;
    int                be_rem;

    assign cur_word  = dout_a[cur_q];
    assign cur_empty = ch_empty[cur_q];
    assign cur_last  = cur_word[DATA_W];
    assign rr_next   = CH_W'((int'(cur_q) + 1) % NUM_CH);
    assign be_rem    = int'(len_q) % BE_W;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            cur_q   <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
            first_q <= first_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cur_d   = cur_q;
        len_d   = len_q;
        first_d = first_q;
        drop_d  = drop_q;
        st_ack  = '0;
        ch_ack  = '0;
        rx_dv   = 1'b0;
        rx_sof  = 1'b0;
        rx_eof  = 1'b0;
        rx_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_v) begin
                    st_ack[gnt_idx] = 1'b1;
                    cur_d   = gnt_idx;
                    len_d   = st_a[gnt_idx][LEN_W-1:0];
                    first_d = 1'b1;
                    // Enable is judged once here; later changes cannot abort.
                    state_d = (st_a[gnt_idx][LEN_W] && chan_en[gnt_idx]) ? ST_XFER : ST_DROP;
                end
            end
            ST_XFER: begin
                rx_dv   = ~cur_empty;
                rx_data = cur_word[DATA_W-1:0];
                rx_sof  = rx_dv & first_q;
                rx_eof  = rx_dv & cur_last;
                if (rx_dv && rx_ack) begin
                    ch_ack[cur_q] = 1'b1;
                    first_d       = 1'b0;
                    if (cur_last) begin
                        state_d = ST_IDLE;
                        rr_d    = rr_next;
                    end
                end
            end
            ST_DROP: begin
                if (!cur_empty) begin
                    ch_ack[cur_q] = 1'b1;
                    if (cur_last) begin
                        drop_d  = drop_q + 32'd1;
                        state_d = ST_IDLE;
                        rr_d    = rr_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Partial byte enables only on the eof word; a zero remainder means the
    // last word is full.
    always_comb begin
        rx_be = '1;
        if (rx_eof && be_rem != 0) begin
            for (int b = 0; b < BE_W; b++) rx_be[b] = (b < be_rem);
        end
    end

    assign rx_ch      = cur_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_rx_usr_if_mc.sv
module tb_rx_usr_if_mc;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int LW  = 14;
    localparam int BEW = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NCH-1:0]         chan_en = '1;
    logic [NCH*(DW+1)-1:0]  ch_dout = '0;
    logic [NCH-1:0]         ch_empty = '1;
    logic [NCH-1:0]         ch_ack;
    logic [NCH*(LW+1)-1:0]  st_dout = '0;
    logic [NCH-1:0]         st_dv = '0;
    logic [NCH-1:0]         st_ack;
    logic [DW-1:0]          rx_data;
    logic [BEW-1:0]         rx_be;
    logic                   rx_sof, rx_eof, rx_dv;
    logic [1:0]             rx_ch;
    logic                   rx_ack = 1'b1;
    logic [31:0]            drop_count;

    always #5 clk = ~clk;

    rx_usr_if_mc #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .chan_en(chan_en),
        .ch_dout(ch_dout), .ch_empty(ch_empty), .ch_ack(ch_ack),
        .st_dout(st_dout), .st_dv(st_dv), .st_ack(st_ack),
        .rx_data(rx_data), .rx_be(rx_be), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_ch(rx_ch), .rx_dv(rx_dv), .rx_ack(rx_ack), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  be;
        logic        sof;
        logic        eof;
        logic [1:0]  ch;
    } word_t;

    // Upstream FIFO emulation (dq/sq) and model copies (md/ms)
    logic [32:0] dq [NCH][$];
    logic [14:0] sq [NCH][$];
    logic [32:0] md [NCH][$];
    logic [14:0] ms [NCH][$];
    word_t exp_q[$];
    word_t log_q[$];
    int mptr = 0, mdrops = 0, mgrants = 0, sack_cnt = 0;
    int n_chk = 0, n_pass = 0;
    bit in_reset = 1'b1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, req);
    endtask

    // FIFO side: pop on the acks seen at the edge, then present new heads.
    always @(posedge clk) begin
        logic [NCH-1:0] a, s;
        a = ch_ack;
        s = st_ack;
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (a[i] && dq[i].size() > 0) void'(dq[i].pop_front());
            if (s[i] && sq[i].size() > 0) begin
                void'(sq[i].pop_front());
                sack_cnt++;
            end
            ch_empty[i] = (dq[i].size() == 0);
            ch_dout[i*(DW+1) +: DW+1] = (dq[i].size() > 0) ? dq[i][0] : '0;
            st_dv[i] = (sq[i].size() != 0);
            st_dout[i*(LW+1) +: LW+1] = (sq[i].size() > 0) ? sq[i][0] : '0;
        end
    end

    // Compare process: every cycle the stream is meaningful.
    always @(negedge clk) begin
        if (!in_reset && reset_n) begin
            if (rx_dv) begin
                word_t got;
                got = {rx_data, rx_be, rx_sof, rx_eof, rx_ch};
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_word: got %0h want none", got);
                end else begin
                    check("word", got, exp_q[0]);
                    if (rx_ack) begin
                        log_q.push_back(got);
                        void'(exp_q.pop_front());
                    end else begin
                        check("stall_no_pop", ch_ack, 0);
                    end
                end
            end else begin
                check("idle_sof_eof", {rx_sof, rx_eof}, 0);
            end
        end
    end

    task automatic add_pkt(input int c, input int nw, input int len, input bit good,
                           input logic [31:0] base);
        logic [32:0] w;
        for (int k = 0; k < nw; k++) begin
            w = {(k == nw - 1), base + 32'(k)};
            dq[c].push_back(w);
            md[c].push_back(w);
        end
        sq[c].push_back({good, 14'(len)});
        ms[c].push_back({good, 14'(len)});
    endtask

    // Packet-level model: resolve all pending statuses in round-robin order.
    task automatic model_run();
        int c, r;
        logic [14:0] st;
        logic [32:0] w;
        logic [3:0]  be;
        bit keep, first;
        forever begin
            c = -1;
            for (int k = 0; k < NCH; k++)
                if (c < 0 && ms[(mptr + k) % NCH].size() > 0) c = (mptr + k) % NCH;
            if (c < 0) break;
            st = ms[c].pop_front();
            mgrants++;
            keep  = st[14] && chan_en[c];
            first = 1'b1;
            r = int'(st[13:0]) % BEW;
            do begin
                w = md[c].pop_front();
                if (keep) begin
                    be = (w[32] && r != 0) ? 4'((1 << r) - 1) : 4'hF;
                    exp_q.push_back(word_t'({w[31:0], be, first, w[32], 2'(c)}));
                end
                first = 1'b0;
            end while (!w[32]);
            if (!keep) mdrops++;
            mptr = (c + 1) % NCH;
        end
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        bit busy;
        cyc = 0;
        do begin
            @(posedge clk); #2;
            cyc++;
            busy = (exp_q.size() != 0);
            for (int i = 0; i < NCH; i++) busy |= (dq[i].size() != 0) || (sq[i].size() != 0);
        end while (busy && cyc < 600);
        check(nm, busy, 0);
        repeat (3) @(posedge clk);
        #2;
        check({nm, "_drops"}, drop_count, mdrops);
        check({nm, "_grants"}, sack_cnt, mgrants);
    endtask

    task automatic wait_log(input int n, input string nm);
        int cyc;
        cyc = 0;
        while (log_q.size() < n && cyc < 400) begin
            @(posedge clk); #2;
            cyc++;
        end
        check(nm, log_q.size() >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int s0;
        #3;
        check("rst_outs", {rx_dv, rx_sof, rx_eof, ch_ack, st_ack, rx_ch}, 0);
        check("rst_be", rx_be, 4'hF);
        check("rst_drop", drop_count, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        in_reset = 1'b0;

        // ch0 and ch2 together, rr=0: ch0 first
        log_q.delete();
        add_pkt(0, 2, 8, 1'b1, 32'hC0);
        add_pkt(2, 2, 8, 1'b1, 32'hD0);
        model_run();
        wait_done("s3a_done");
        check("s3a_order", {log_q[0].ch, log_q[1].ch, log_q[2].ch, log_q[3].ch}, 8'h0A);
        check("s3a_d2", log_q[2].d, 32'hD0);

        // single good packet on ch0, len 10, 3 words
        log_q.delete();
        add_pkt(0, 3, 10, 1'b1, 32'hA0);
        model_run();
        check("mdl_size", exp_q.size(), 3);
        check("mdl_be", exp_q[2].be, 4'b0011);
        wait_done("s1_done");
        check("s1_n", log_q.size(), 3);
        check("s1_be", {log_q[0].be, log_q[1].be, log_q[2].be}, 12'hFF3);
        check("s1_sof", {log_q[0].sof, log_q[1].sof, log_q[2].sof}, 3'b100);
        check("s1_eof", {log_q[0].eof, log_q[1].eof, log_q[2].eof}, 3'b001);
        check("s1_ch_d", {log_q[2].ch, log_q[2].d}, {2'd0, 32'hA2});
        check("s1_drop", drop_count, 0);

        // rr=1: pending ch0 loses to ch3
        log_q.delete();
        add_pkt(0, 2, 4, 1'b1, 32'hE0);
        add_pkt(3, 2, 4, 1'b1, 32'hF0);
        model_run();
        wait_done("s3b_done");
        check("s3b_first", log_q[0].ch, 2'd3);
        check("s3b_second", log_q[2].ch, 2'd0);

        // bad packet on ch1
        log_q.delete();
        s0 = sack_cnt;
        add_pkt(1, 2, 8, 1'b0, 32'hB0);
        model_run();
        wait_done("s2_done");
        check("s2_drop", drop_count, 1);
        check("s2_stack", sack_cnt - s0, 1);
        check("s2_nodata", log_q.size(), 0);
        check("s2_popped", dq[1].size(), 0);

        // stall 5 cycles mid-packet
        log_q.delete();
        add_pkt(1, 4, 16, 1'b1, 32'h10);
        model_run();
        wait_log(2, "s4_start");
        rx_ack = 1'b0;
        repeat (5) @(posedge clk);
        #2 rx_ack = 1'b1;
        wait_done("s4_done");
        check("s4_seq", {log_q[0].d[7:0], log_q[1].d[7:0], log_q[2].d[7:0], log_q[3].d[7:0]},
              32'h10111213);
        check("s4_be_full", log_q[3].be, 4'hF);

        // disabled channel drops a good packet
        log_q.delete();
        chan_en[3] = 1'b0;
        add_pkt(3, 2, 5, 1'b1, 32'h20);
        model_run();
        wait_done("s5a_done");
        check("s5a_drop", drop_count, 2);
        chan_en = '1;

        // enable change in flight does not abort
        log_q.delete();
        add_pkt(2, 3, 12, 1'b1, 32'h30);
        model_run();
        wait_log(1, "s5b_start");
        chan_en[2] = 1'b0;
        wait_done("s5b_done");
        check("s5b_n", log_q.size(), 3);
        chan_en = '1;

        // async reset mid-transfer
        log_q.delete();
        add_pkt(1, 4, 16, 1'b1, 32'h40);
        model_run();
        wait_log(1, "s6_start");
        @(posedge clk);
        #3;
        in_reset = 1'b1;
        reset_n = 1'b0;
        #1;
        check("s6_outs", {rx_dv, rx_sof, rx_eof, ch_ack, st_ack, rx_ch}, 0);
        check("s6_be", rx_be, 4'hF);
        check("s6_drop", drop_count, 0);
        for (int i = 0; i < NCH; i++) begin
            dq[i].delete(); sq[i].delete(); md[i].delete(); ms[i].delete();
        end
        exp_q.delete();
        mptr = 0; mdrops = 0; mgrants = 0; sack_cnt = 0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        in_reset = 1'b0;
        log_q.delete();
        add_pkt(2, 2, 7, 1'b1, 32'h50);
        model_run();
        wait_done("s6_done");
        check("s6_first", {log_q[0].sof, log_q[0].ch, log_q[0].d}, {1'b1, 2'd2, 32'h50});
        check("s6_be_eof", log_q[1].be, 4'b0111);
        check("s6_drop_after", drop_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
